// File: rtl/axi4_mem_rw_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi4_mem_rw_bridge
// Brief    : AXI4 INCR-burst slave that issues one 64-bit helper access per beat.
//            Optional build macro MEM_RANGE_CHECK_EN suppresses out-of-range beats.
// Revision : 1.0
// ============================================================================
module axi4_mem_rw_bridge #(
   parameter int unsigned       ADDR_W = 32,
   parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000
`ifdef MEM_RANGE_CHECK_EN
   ,parameter logic [63:0]      MEM_WORDS = 64'h0000_0000_1000_0000
`endif
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              awvalid,
   output logic              awready,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [7:0]        awlen,
   input  logic              wvalid,
   output logic              wready,
   input  logic [63:0]       wdata,
   input  logic [7:0]        wstrb,
   input  logic              wlast,
   output logic              bvalid,
   input  logic              bready,
   output logic [1:0]        bresp,
   input  logic              arvalid,
   output logic              arready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [7:0]        arlen,
   output logic              rvalid,
   input  logic              rready,
   output logic [63:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              r_enable,
   output logic [63:0]       r_index,
   input  logic [63:0]       r_data,
   output logic              w_enable,
   output logic [63:0]       w_index,
   output logic [63:0]       w_data,
   output logic [63:0]       w_mask
);

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_DATA = 2'd2} rstate_t;

   // Subtract in ADDR_W bits first so addresses below BASE wrap, then zero-extend.
   function automatic logic [63:0] word_index(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] diff;
      diff = addr - BASE;
      return 64'(diff >> 3);
   endfunction

   function automatic logic [63:0] expand(input logic [7:0] strb);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{strb[i]}};
      return m;
   endfunction

   wstate_t     wstate, wstate_nx;
   rstate_t     rstate, rstate_nx;
   logic [63:0] widx, ridx, aw_idx, ar_idx;
   logic [7:0]  wcnt, rcnt;
   logic        wslv, wdec, wslv_nx, wdec_nx;
   logic        roob;
   logic        w_oob, ar_oob, rn_oob;
   logic        aw_hs, w_hs, ar_hs, r_hs;

   assign aw_idx = word_index(awaddr);
   assign ar_idx = word_index(araddr);

`ifdef MEM_RANGE_CHECK_EN
   assign w_oob  = (widx >= MEM_WORDS);
   assign ar_oob = (ar_idx >= MEM_WORDS);
   assign rn_oob = ((ridx + 64'd1) >= MEM_WORDS);
`else
   assign w_oob  = 1'b0;
   assign ar_oob = 1'b0;
   assign rn_oob = 1'b0;
`endif

   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;
   assign ar_hs = arvalid & arready;
   assign r_hs  = rvalid & rready;

   assign wslv_nx = wslv | (wlast != (wcnt == 8'd0));
   assign wdec_nx = wdec | w_oob;

   // ---------------- write channel ----------------
   always_ff @(posedge clock) begin
      if (reset) wstate <= W_IDLE;
      else       wstate <= wstate_nx;
   end

   always_comb begin
      wstate_nx = wstate;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      case (wstate)
         W_IDLE: begin
            awready = !reset;
            if (awvalid) wstate_nx = W_DATA;
         end
         W_DATA: begin
            wready = !reset;
            if (wvalid && wcnt == 8'd0) wstate_nx = W_RESP;
         end
         W_RESP: begin
            bvalid = !reset;
            if (bready) wstate_nx = W_IDLE;
         end
         default: wstate_nx = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         widx     <= '0;
         wcnt     <= '0;
         wslv     <= 1'b0;
         wdec     <= 1'b0;
         bresp    <= 2'b00;
         w_enable <= 1'b0;
         w_index  <= '0;
         w_data   <= '0;
         w_mask   <= '0;
      end else begin
         w_enable <= 1'b0;
         if (aw_hs) begin
            widx <= aw_idx;
            wcnt <= awlen;
            wslv <= 1'b0;
            wdec <= 1'b0;
         end
         if (w_hs) begin
            w_enable <= !w_oob;
            w_index  <= widx;
            w_data   <= wdata;
            w_mask   <= expand(wstrb);
            widx     <= widx + 64'd1;
            wcnt     <= wcnt - 8'd1;
            wslv     <= wslv_nx;
            wdec     <= wdec_nx;
            // Decode error outranks a framing error when both occur in one burst.
            if (wcnt == 8'd0)
               bresp <= wdec_nx ? 2'b11 : (wslv_nx ? 2'b10 : 2'b00);
         end
      end
   end

   // ---------------- read channel ----------------
   always_ff @(posedge clock) begin
      if (reset) rstate <= R_IDLE;
      else       rstate <= rstate_nx;
   end

   always_comb begin
      rstate_nx = rstate;
      arready   = 1'b0;
      r_enable  = 1'b0;
      rvalid    = 1'b0;
      case (rstate)
         R_IDLE: begin
            arready = !reset;
            if (arvalid) rstate_nx = ar_oob ? R_DATA : R_REQ;
         end
         R_REQ: begin
            r_enable  = !reset;
            rstate_nx = R_DATA;
         end
         R_DATA: begin
            rvalid = !reset;
            if (rready) begin
               if (rcnt == 8'd0) rstate_nx = R_IDLE;
               else              rstate_nx = rn_oob ? R_DATA : R_REQ;
            end
         end
         default: rstate_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ridx <= '0;
         rcnt <= '0;
         roob <= 1'b0;
      end else if (ar_hs) begin
         ridx <= ar_idx;
         rcnt <= arlen;
         roob <= ar_oob;
      end else if (r_hs && rcnt != 8'd0) begin
         ridx <= ridx + 64'd1;
         rcnt <= rcnt - 8'd1;
         roob <= rn_oob;
      end
   end

   // Helper holds r_data until its next r_enable, so passing it through stays stable.
   assign r_index = ridx;
   assign rdata   = (rvalid && !roob) ? r_data : 64'd0;
   assign rresp   = (rvalid && roob) ? 2'b11 : 2'b00;
   assign rlast   = rvalid && (rcnt == 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_rw_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_mem_rw_bridge
// Brief    : Scoreboard bench for axi4_mem_rw_bridge with a behavioural helper memory.
// Revision : 1.0
// ============================================================================
module tb_axi4_mem_rw_bridge;

   localparam logic [63:0] ALL  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] LOW4 = 64'h0000_0000_FFFF_FFFF;
   localparam logic [63:0] INIT = 64'hDEAD_0000_0000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen, wstrb;
   logic [63:0] wdata;
   logic [1:0]  bresp, rresp;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [63:0] rdata;
   logic        r_enable, w_enable;
   logic [63:0] r_index, w_index, w_data, w_mask;
   logic [63:0] r_data = '0;

   always #5 clock = ~clock;

   axi4_mem_rw_bridge dut (
      .clock(clock), .reset(reset),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .r_enable(r_enable), .r_index(r_index), .r_data(r_data),
      .w_enable(w_enable), .w_index(w_index), .w_data(w_data), .w_mask(w_mask)
   );

   // Helper model: same-edge read sees the pre-write contents.
   logic [63:0] mem [0:255];
   logic        mem_loaded = 1'b0;
   always @(posedge clock) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= INIT + 64'(i);
         mem_loaded <= 1'b1;
      end else begin
         if (r_enable) r_data <= mem[r_index[7:0]];
         if (w_enable) mem[w_index[7:0]] <= (mem[w_index[7:0]] & ~w_mask) | (w_data & w_mask);
      end
   end

   typedef struct packed {logic [63:0] idx; logic [63:0] data; logic [63:0] mask;} wexp_t;
   typedef struct packed {logic [63:0] data; logic [1:0] resp; logic last;} rexp_t;
   wexp_t       exp_w[$];
   rexp_t       exp_r[$];
   logic [63:0] exp_ri[$];
   logic [1:0]  exp_b[$];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexp(input string name);
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got an event, expected none", name);
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no handshake, expected one within 50 cycles", name);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an output.
   wexp_t       mw;
   rexp_t       mr;
   logic [63:0] mi;
   logic [1:0]  mb;
   always @(negedge clock) begin
      if (w_enable) begin
         if (exp_w.size() == 0) unexp("w_enable");
         else begin
            mw = exp_w.pop_front();
            chk("w_index", 192'(w_index), 192'(mw.idx));
            chk("w_data",  192'(w_data),  192'(mw.data));
            chk("w_mask",  192'(w_mask),  192'(mw.mask));
         end
      end
      if (r_enable) begin
         if (exp_ri.size() == 0) unexp("r_enable");
         else begin
            mi = exp_ri.pop_front();
            chk("r_index", 192'(r_index), 192'(mi));
         end
      end
      if (bvalid && bready) begin
         if (exp_b.size() == 0) unexp("bvalid");
         else begin
            mb = exp_b.pop_front();
            chk("bresp", 192'(bresp), 192'(mb));
         end
      end
      // Stalled beats are compared every cycle, so instability is caught too.
      if (rvalid) begin
         if (exp_r.size() == 0) unexp("rvalid");
         else begin
            mr = exp_r[0];
            chk("rdata", 192'(rdata), 192'(mr.data));
            chk("rresp", 192'(rresp), 192'(mr.resp));
            chk("rlast", 192'(rlast), 192'(mr.last));
            if (rready) void'(exp_r.pop_front());
         end
      end
   end

   task automatic aw_send(input logic [31:0] a, input logic [7:0] l);
      int n = 0;
      awaddr = a; awlen = l; awvalid = 1'b1;
      @(negedge clock);
      while (!awready && n < 50) begin @(negedge clock); n++; end
      if (!awready) timeout("aw");
      @(posedge clock); #1 awvalid = 1'b0;
   endtask

   task automatic ar_send(input logic [31:0] a, input logic [7:0] l);
      int n = 0;
      araddr = a; arlen = l; arvalid = 1'b1;
      @(negedge clock);
      while (!arready && n < 50) begin @(negedge clock); n++; end
      if (!arready) timeout("ar");
      @(posedge clock); #1 arvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
      int n = 0;
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      @(negedge clock);
      while (!wready && n < 50) begin @(negedge clock); n++; end
      if (!wready) timeout("w");
      @(posedge clock); #1 wvalid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_w.size() + exp_r.size() + exp_ri.size() + exp_b.size()) != 0 && n < 200) begin
         @(negedge clock); n++;
      end
      chk("drain_pending", 192'(exp_w.size() + exp_r.size() + exp_ri.size() + exp_b.size()), 192'(0));
      repeat (2) @(negedge clock);
      @(posedge clock); #1;
   endtask

   initial begin
      reset = 1'b1; awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b0;
      awaddr = 32'h8000_0000; araddr = 32'h8000_0000; awlen = '0; arlen = '0;
      wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b1; rready = 1'b1;

      // Reset with requests pending: nothing may be accepted.
      repeat (2) begin
         @(negedge clock);
         chk("awready_in_reset", 192'(awready), 192'(0));
         chk("arready_in_reset", 192'(arready), 192'(0));
      end
      @(posedge clock); #1 reset = 1'b0; awvalid = 1'b0; arvalid = 1'b0;
      @(negedge clock);
      chk("awready_after_reset", 192'(awready), 192'(1));
      chk("arready_after_reset", 192'(arready), 192'(1));
      chk("idle_outputs", 192'({bvalid, rvalid, rlast, wready, w_enable, r_enable, bresp, rresp}), 192'(0));
      chk("idle_helper_regs", {w_index, w_data, w_mask}, 192'(0));
      @(posedge clock); #1;

      // Four-beat write at index 2, partial strobe on the last beat.
      exp_w.push_back({64'd2, 64'd1, ALL});
      exp_w.push_back({64'd3, 64'd2, ALL});
      exp_w.push_back({64'd4, 64'd3, ALL});
      exp_w.push_back({64'd5, 64'd4, LOW4});
      exp_b.push_back(2'b00);
      fork
         aw_send(32'h8000_0010, 8'd3);
         begin
            w_beat(64'd1, 8'hFF, 1'b0);
            w_beat(64'd2, 8'hFF, 1'b0);
            w_beat(64'd3, 8'hFF, 1'b0);
            w_beat(64'd4, 8'h0F, 1'b1);
         end
      join
      drain();

      // Two-beat read back with the first beat stalled.
      rready = 1'b0;
      exp_ri.push_back(64'd2);
      exp_ri.push_back(64'd3);
      exp_r.push_back({64'd1, 2'b00, 1'b0});
      exp_r.push_back({64'd2, 2'b00, 1'b1});
      ar_send(32'h8000_0010, 8'd1);
      begin
         int n = 0;
         @(negedge clock);
         while (!rvalid && n < 50) begin @(negedge clock); n++; end
         if (!rvalid) timeout("rvalid");
      end
      repeat (3) @(negedge clock);
      @(posedge clock); #1 rready = 1'b1;
      drain();

      // Concurrent AW/AR at index 8: the beat-2 read meets the index-9 write.
      exp_w.push_back({64'd8, 64'h1111, ALL});
      exp_w.push_back({64'd9, 64'h2222, ALL});
      exp_b.push_back(2'b00);
      exp_ri.push_back(64'd8);
      exp_ri.push_back(64'd9);
      exp_r.push_back({INIT + 64'd8, 2'b00, 1'b0});
      exp_r.push_back({INIT + 64'd9, 2'b00, 1'b1});
      fork
         aw_send(32'h8000_0040, 8'd1);
         ar_send(32'h8000_0040, 8'd1);
         begin
            w_beat(64'h1111, 8'hFF, 1'b0);
            w_beat(64'h2222, 8'hFF, 1'b1);
         end
      join
      drain();
      exp_ri.push_back(64'd8);
      exp_ri.push_back(64'd9);
      exp_r.push_back({64'h1111, 2'b00, 1'b0});
      exp_r.push_back({64'h2222, 2'b00, 1'b1});
      ar_send(32'h8000_0040, 8'd1);
      drain();

      // Reset after the first beat of a four-beat write.
      exp_w.push_back({64'd16, 64'h55, ALL});
      fork
         aw_send(32'h8000_0080, 8'd3);
         w_beat(64'h55, 8'hFF, 1'b0);
      join
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("reset_mid_burst_outputs", 192'({w_enable, bvalid, wready}), 192'(0));
      @(posedge clock); #1 reset = 1'b0;
      drain();
      exp_w.push_back({64'd16, 64'h77, LOW4});
      exp_b.push_back(2'b00);
      fork
         aw_send(32'h8000_0080, 8'd0);
         w_beat(64'h77, 8'h0F, 1'b1);
      join
      drain();

      // Early wlast on a two-beat burst: both beats written, SLVERR.
      exp_w.push_back({64'd24, 64'hA, ALL});
      exp_w.push_back({64'd25, 64'hB, ALL});
      exp_b.push_back(2'b10);
      fork
         aw_send(32'h8000_00C0, 8'd1);
         begin
            w_beat(64'hA, 8'hFF, 1'b1);
            w_beat(64'hB, 8'hFF, 1'b1);
         end
      join
      drain();

`ifdef MEM_RANGE_CHECK_EN
      // BASE + 8*MEM_WORDS wraps to 0 in 32 bits, giving index MEM_WORDS.
      exp_r.push_back({64'd0, 2'b11, 1'b1});
      ar_send(32'h0000_0000, 8'd0);
      drain();
      exp_b.push_back(2'b11);
      fork
         aw_send(32'h0000_0000, 8'd0);
         w_beat(64'h99, 8'hFF, 1'b1);
      join
      drain();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
